// File: rtl/inst_encode_writer_pkg.sv
// inst_encode_writer_pkg: instruction type/opcode codes, error bit codes, FSM states and the immediate range helper
package inst_encode_writer_pkg;
  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [1:0] ERR_IMM  = 2'b01;
  localparam logic [1:0] ERR_WRAP = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_t;
  function automatic logic sext_ok(input logic [31:0] imm, input int lsb);
    logic [31:0] s;
    s = $signed(imm) >>> lsb;
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/inst_encode_writer_pack.sv
// inst_pack: combinational RV32I field packer (in: typ/opcode/rd/rs1/rs2/funct3/funct7/imm; out: word, imm_err)
module inst_pack
  import inst_encode_writer_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_err
);
  logic shift;
  assign shift = opcode == OPCODE_OP_IMM && funct3[1:0] == 2'b01;
  always_comb begin
    word = {imm[11:0], rs1, funct3, rd, opcode};
    imm_err = !sext_ok(imm, 11);
    case (typ)
      TYPE_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
        imm_err = 1'b0;
      end
      TYPE_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      TYPE_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        imm_err = !sext_ok(imm, 12) || imm[0];
      end
      TYPE_U: begin
        word = {imm[31:12], rd, opcode};
        imm_err = imm[11:0] != '0;
      end
      TYPE_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        imm_err = !sext_ok(imm, 20) || imm[0];
      end
      default: if (shift) begin
        word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        imm_err = imm[31:5] != '0;
      end
    endcase
  end
endmodule

// File: rtl/inst_encode_writer.sv
// inst_encode_writer: packs field tuples, queues them in a FIFO, writes them to imem at consecutive addresses (in: start, in_* tuple handshake, imem_ready; out: imem_we/addr/wdata, busy, done, err, err_addr, count)
module inst_encode_writer
  import inst_encode_writer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [31:0] mem_w [DEPTH];
  logic [DEPTH-1:0] mem_e;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] occ;
  logic [31:0] enc_word;
  logic enc_err, full, empty, push, pop;
  logic [1:0] new_err;
  logic [ADDR_W-1:0] addr;
  inst_pack u_pack (
    .typ(in_type), .opcode(in_opcode), .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2),
    .funct3(in_funct3), .funct7(in_funct7), .imm(in_imm),
    .word(enc_word), .imm_err(enc_err)
  );
  assign full = occ == (PW+1)'(DEPTH);
  assign empty = occ == '0;
  assign in_ready = state == ST_RUN && !full && !start;
  assign push = in_valid && in_ready;
  assign imem_we = !empty && (state == ST_RUN || state == ST_FLUSH);
  assign pop = imem_we && imem_ready;
  assign imem_addr = addr;
  assign imem_wdata = empty ? '0 : mem_w[rd_ptr];
  assign busy = state == ST_RUN || state == ST_FLUSH;
  assign done = state == ST_DONE;
  // errors are judged at write time so err_addr names the word's real address
  assign new_err = (mem_e[rd_ptr] ? ERR_IMM : 2'b00) | (&addr ? ERR_WRAP : 2'b00);
  always_comb begin
    state_nx = state;
    if (start) state_nx = ST_RUN;
    else if (state == ST_RUN && push && in_last) state_nx = ST_FLUSH;
    else if (state == ST_FLUSH && empty) state_nx = ST_DONE;
  end
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst || start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_w[wr_ptr] <= enc_word;
      mem_e[wr_ptr] <= enc_err;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || start) begin
      addr <= ADDR_W'(BASE_ADDR);
      count <= '0;
      err <= '0;
      err_addr <= '0;
    end else if (pop) begin
      addr <= addr + ADDR_W'(1);
      count <= count + ADDR_W'(1);
      err <= err | new_err;
      if (err == '0 && new_err != '0) err_addr <= addr;
    end
  end
endmodule
